// File: rtl/result_format_ctrl.sv
// Signed result / remainder to 8-digit display word formatter.
// Ports: clock, reset, start, remain, alu_result, alu_remainder -> busy, done, overflow, formattedresult.
module result_format_ctrl #(
  parameter int WIDTH  = 21,
  parameter int DIGITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  remain,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic [WIDTH-1:0]      alu_remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   formattedresult
);

  // BCD digits needed for a WIDTH-bit unsigned value (log10(2) ~ 0.30103)
  localparam int BD = (WIDTH * 30103) / 100000 + 1;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CONV_Q   = 3'd1;
  localparam logic [2:0] S_CONV_R   = 3'd2;
  localparam logic [2:0] S_ASSEMBLE = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]          state;
  logic [CW-1:0]       cnt;
  logic [WIDTH-1:0]    sh;
  logic [WIDTH-1:0]    rem_l;
  logic [4*BD-1:0]     bcd;
  logic [4*BD-1:0]     adj;
  logic [4*BD-1:0]     bcd_nxt;
  logic [4*BD-1:0]     qd;
  logic [4*BD-1:0]     rd;
  logic [3:0]          qlen;
  logic [3:0]          rlen;
  logic                mode;
  logic                neg;
  logic                last;
  logic [4*DIGITS-1:0] word;
  logic                ovf;

  function automatic logic [3:0] len_of(input logic [4*BD-1:0] d);
    logic [3:0] l;
    l = 4'd1;
    for (int i = 1; i < BD; i++) begin
      if (d[4*i +: 4] != 4'd0) l = 4'(i + 1);
    end
    return l;
  endfunction

  // One double-dabble step: add-3 correction, then shift in the next MSB
  always_comb begin
    adj = bcd;
    for (int i = 0; i < BD; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    bcd_nxt = {adj[4*BD-2:0], sh[WIDTH-1]};
  end

  assign last = (cnt == CW'(WIDTH - 1));

  // Right-aligned word: [rem digits][A][result digits][E], rest blank
  always_comb begin
    int lq;
    int lr;
    int n;
    lq   = int'(qlen);
    lr   = int'(rlen);
    n    = int'(neg);
    word = '1;
    ovf  = mode && ((lq + lr + 1 + n) > DIGITS);
    for (int p = 0; p < DIGITS; p++) begin
      if (!mode) begin
        if (p < lq) word[4*p +: 4] = qd[4*p +: 4];
        else if (p == lq && neg) word[4*p +: 4] = 4'hE;
      end else begin
        if (p < lr) word[4*p +: 4] = rd[4*p +: 4];
        else if (p == lr) word[4*p +: 4] = 4'hA;
        else if (p <= lr + lq) word[4*p +: 4] = qd[4*(p-lr-1) +: 4];
        else if (p == lr + lq + 1 && neg) word[4*p +: 4] = 4'hE;
      end
    end
    if (ovf) word = {DIGITS{4'hE}};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      cnt             <= '0;
      sh              <= '0;
      rem_l           <= '0;
      bcd             <= '0;
      qd              <= '0;
      rd              <= '0;
      qlen            <= 4'd1;
      rlen            <= 4'd1;
      mode            <= 1'b0;
      neg             <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      overflow        <= 1'b0;
      formattedresult <= '1;
    end else begin
      done <= 1'b0;
      case (state)
        // DONE accepts start too, so a held start re-triggers right after done
        S_IDLE, S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
          if (start) begin
            mode  <= remain;
            neg   <= alu_result[WIDTH-1];
            sh    <= alu_result[WIDTH-1] ? -alu_result : alu_result;
            rem_l <= alu_remainder;
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_CONV_Q;
          end
        end
        S_CONV_Q: begin
          bcd <= bcd_nxt;
          sh  <= sh << 1;
          cnt <= cnt + 1'b1;
          if (last) begin
            qd    <= bcd_nxt;
            qlen  <= len_of(bcd_nxt);
            bcd   <= '0;
            cnt   <= '0;
            sh    <= rem_l;
            state <= mode ? S_CONV_R : S_ASSEMBLE;
          end
        end
        S_CONV_R: begin
          bcd <= bcd_nxt;
          sh  <= sh << 1;
          cnt <= cnt + 1'b1;
          if (last) begin
            rd    <= bcd_nxt;
            rlen  <= len_of(bcd_nxt);
            state <= S_ASSEMBLE;
          end
        end
        S_ASSEMBLE: begin
          formattedresult <= word;
          overflow        <= ovf;
          done            <= 1'b1;
          busy            <= 1'b0;
          state           <= S_DONE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_format_ctrl.sv
// Self-checking bench for result_format_ctrl.
// Drives directed and random operands and compares against a decimal model.
module tb_result_format_ctrl;

  logic        clock;
  logic        reset;
  logic        start;
  logic        remain;
  logic [20:0] alu_result;
  logic [20:0] alu_remainder;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [31:0] formattedresult;

  int checks = 0;
  int fails  = 0;

  result_format_ctrl dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .remain          (remain),
    .alu_result      (alu_result),
    .alu_remainder   (alu_remainder),
    .busy            (busy),
    .done            (done),
    .overflow        (overflow),
    .formattedresult (formattedresult)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Decimal reference: list nibbles rightmost-first, then pack or overflow
  function automatic void model(input logic [20:0] r, input logic [20:0] rm,
                                input bit rem, output logic [31:0] w,
                                output bit ov);
    int q[$];
    int mag;
    int rmag;
    bit ng;
    ng  = r[20];
    mag = ng ? (1 << 21) - int'(r) : int'(r);
    if (rem) begin
      rmag = int'(rm);
      do begin
        q.push_back(rmag % 10);
        rmag = rmag / 10;
      end while (rmag > 0);
      q.push_back(10);
    end
    do begin
      q.push_back(mag % 10);
      mag = mag / 10;
    end while (mag > 0);
    if (ng) q.push_back(14);
    if (q.size() > 8) begin
      w  = 32'hEEEEEEEE;
      ov = 1'b1;
    end else begin
      w  = '1;
      ov = 1'b0;
      for (int i = 0; i < q.size(); i++) w[4*i +: 4] = 4'(q[i]);
    end
  endfunction

  // Start one op; lat = negedges after the accepting edge until done
  task automatic do_op(input logic [20:0] r, input logic [20:0] rm,
                       input bit rem, output int lat, output bit busy_ok,
                       output logic [31:0] w, output bit ov);
    @(negedge clock);
    alu_result    = r;
    alu_remainder = rm;
    remain        = rem;
    start         = 1'b1;
    @(negedge clock);
    start         = 1'b0;
    alu_result    = 21'($urandom);
    alu_remainder = 21'($urandom);
    remain        = ~rem;
    lat     = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clock);
      lat++;
    end
    if (busy !== 1'b0) busy_ok = 1'b0;
    w  = formattedresult;
    ov = overflow;
  endtask

  task automatic test_reset;
    checks++;
    if (formattedresult !== 32'hFFFFFFFF) begin
      fails++;
      $display("FAIL reset_word got %h want FFFFFFFF", formattedresult);
    end
    checks++;
    if ({busy, done, overflow} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags got busy/done/ovf %b want 000",
               {busy, done, overflow});
    end
  endtask

  task automatic test_result_only;
    logic [20:0] rv[4];
    logic [31:0] ev[4];
    int lat;
    bit bok;
    logic [31:0] w;
    bit ov;
    rv[0] = 21'd1234;   ev[0] = 32'hFFFF1234;
    rv[1] = 21'h1FFFD3; ev[1] = 32'hFFFFFE45;
    rv[2] = 21'd0;      ev[2] = 32'hFFFFFFF0;
    rv[3] = 21'h100000; ev[3] = 32'hE1048576;
    for (int i = 0; i < 4; i++) begin
      do_op(rv[i], 21'd0, 1'b0, lat, bok, w, ov);
      checks++;
      if (lat != 22) begin
        fails++;
        $display("FAIL ro_latency[%0d] got %0d want 22", i, lat);
      end
      checks++;
      if (!bok) begin
        fails++;
        $display("FAIL ro_busy[%0d] got busy wrong want high until done", i);
      end
      checks++;
      if (w !== ev[i] || ov !== 1'b0) begin
        fails++;
        $display("FAIL ro_word[%0d] got %h/%b want %h/0", i, w, ov, ev[i]);
      end
      @(negedge clock);
      checks++;
      if (done !== 1'b0 || formattedresult !== ev[i]) begin
        fails++;
        $display("FAIL ro_hold[%0d] got done %b word %h want 0 %h",
                 i, done, formattedresult, ev[i]);
      end
    end
  endtask

  task automatic test_with_remainder;
    logic [20:0] rv[4];
    logic [20:0] mv[4];
    bit          sv[4];
    logic [31:0] ev[4];
    bit          ovv[4];
    int          lv[4];
    int lat;
    bit bok;
    logic [31:0] w;
    bit ov;
    rv[0] = 21'd17;      mv[0] = 21'd3; sv[0] = 1; ev[0] = 32'hFFFF17A3;
    rv[1] = 21'h1FFFFE;  mv[1] = 21'd0; sv[1] = 1; ev[1] = 32'hFFFFE2A0;
    rv[2] = 21'd1048575; mv[2] = 21'd5; sv[2] = 1; ev[2] = 32'hEEEEEEEE;
    rv[3] = 21'd7;       mv[3] = 21'd9; sv[3] = 0; ev[3] = 32'hFFFFFFF7;
    ovv[0] = 0; ovv[1] = 0; ovv[2] = 1; ovv[3] = 0;
    lv[0] = 43; lv[1] = 43; lv[2] = 43; lv[3] = 22;
    for (int i = 0; i < 4; i++) begin
      do_op(rv[i], mv[i], sv[i], lat, bok, w, ov);
      checks++;
      if (lat != lv[i] || !bok) begin
        fails++;
        $display("FAIL rem_timing[%0d] got lat %0d busy_ok %b want %0d 1",
                 i, lat, bok, lv[i]);
      end
      checks++;
      if (w !== ev[i] || ov !== ovv[i]) begin
        fails++;
        $display("FAIL rem_word[%0d] got %h/%b want %h/%b",
                 i, w, ov, ev[i], ovv[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [20:0] r;
    logic [20:0] rm;
    bit rem;
    int lat;
    bit bok;
    logic [31:0] w;
    logic [31:0] ew;
    bit ov;
    bit eov;
    for (int i = 0; i < 40; i++) begin
      r   = 21'($urandom);
      if (i % 3 == 0) r = 21'($urandom_range(0, 999));
      rm  = (i % 2 == 0) ? 21'($urandom_range(0, 99)) : 21'($urandom);
      rem = 1'($urandom);
      model(r, rm, rem, ew, eov);
      do_op(r, rm, rem, lat, bok, w, ov);
      checks++;
      if (w !== ew || ov !== eov || lat != (rem ? 43 : 22) || !bok) begin
        fails++;
        $display("FAIL rand[%0d] r=%h m=%h s=%b got %h/%b lat %0d want %h/%b",
                 i, r, rm, rem, w, ov, lat, ew, eov);
      end
    end
  endtask

  task automatic test_ignored_start;
    int lat;
    @(negedge clock);
    alu_result = 21'd1234; alu_remainder = 21'd0; remain = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (lat == 4) begin
        alu_result = 21'd99; alu_remainder = 21'd4; remain = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      lat++;
    end
    start = 1'b0;
    checks++;
    if (lat != 22 || formattedresult !== 32'hFFFF1234) begin
      fails++;
      $display("FAIL ignored_start got lat %0d word %h want 22 FFFF1234",
               lat, formattedresult);
    end
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL not_queued got busy %b done %b want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    bit bok;
    bit seen;
    logic [31:0] w;
    bit ov;
    do_op(21'd1048575, 21'd5, 1'b1, lat, bok, w, ov);
    @(negedge clock);
    alu_result = 21'd4321; alu_remainder = 21'd0; remain = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (formattedresult !== 32'hFFFFFFFF || busy !== 1'b0 ||
        done !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid got %h b%b d%b o%b want FFFFFFFF 0 0 0",
               formattedresult, busy, done, overflow);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      fails++;
      $display("FAIL reset_abort got done/busy activity want none");
    end
    do_op(21'd1234, 21'd0, 1'b0, lat, bok, w, ov);
    checks++;
    if (lat != 22 || w !== 32'hFFFF1234 || ov !== 1'b0) begin
      fails++;
      $display("FAIL after_reset got lat %0d %h/%b want 22 FFFF1234/0",
               lat, w, ov);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clock);
    alu_result = 21'd5; alu_remainder = 21'd0; remain = 1'b0; start = 1'b1;
    @(negedge clock);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    checks++;
    if (lat != 22 || formattedresult !== 32'hFFFFFFF5) begin
      fails++;
      $display("FAIL b2b_first got lat %0d %h want 22 FFFFFFF5",
               lat, formattedresult);
    end
    alu_result = 21'h1FFFFD;
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_retrigger got busy %b done %b want 1 0", busy, done);
    end
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    checks++;
    if (lat != 22 || formattedresult !== 32'hFFFFFFE3) begin
      fails++;
      $display("FAIL b2b_second got lat %0d %h want 22 FFFFFFE3",
               lat, formattedresult);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    remain = 1'b0;
    alu_result = '0;
    alu_remainder = '0;
    repeat (3) @(negedge clock);
    test_reset;
    reset = 1'b0;
    test_result_only;
    test_with_remainder;
    test_ignored_start;
    test_random;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end

endmodule
